// File: rtl/control_sequencer_if.sv
// Strobe and IR bundle between the hardwired control sequencer and the Datapath.
// The master modport is the sequencer side; the slave modport is the Datapath side.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        mem_ready;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        MDRout;
    logic        MDMuxread;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [12:0] alu_ctl;
    logic        run;
    logic        illegal;
    logic        mem_timeout;
    logic [3:0]  state;

    modport master (
        input  IR, mem_ready,
        output Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               alu_ctl, run, illegal, mem_timeout, state
    );

    modport slave (
        output IR, mem_ready,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
               IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               alu_ctl, run, illegal, mem_timeout, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions (T0..T6).
// Optional single-step gate: define CONTROL_STEP_EN to add the step input and WAIT_STEP.
//
// state     | meaning
// T0   (0)  | PC -> MAR, PC+1 into Z
// T1   (1)  | wait for mem_ready, then Z -> PC and memory -> MDR
// T2   (2)  | MDR -> IR
// T3   (3)  | Rb -> Y (illegal opcode halts here instead)
// T4   (4)  | ALU op on Y and Rc (or Rb for NEG/NOT) into Z
// T5   (5)  | Zlow -> Ra, or Zlow -> LO for MUL/DIV
// T6   (6)  | Zhigh -> HI (MUL/DIV only)
// HALT (7)  | stopped; only clear leaves
// WAIT (8)  | waiting for step (CONTROL_STEP_EN only)
module control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clock,
    input  logic clear,
`ifdef CONTROL_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);

    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_HALT = 4'd7,
        S_WAIT = 4'd8
    } state_e;

`ifdef CONTROL_STEP_EN
    localparam state_e S_DONE = S_WAIT;
`else
    localparam state_e S_DONE = S_T0;
`endif

    state_e         state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;

    logic [4:0]     opcode;
    logic [3:0]     ra, rb, rc;
    logic [12:0]    alu_sel;
    logic           op_legal;
    logic           is_muldiv;
    logic           is_unary;
    logic           unused_ir;

    assign opcode    = bus.IR[31:27];
    assign ra        = bus.IR[26:23];
    assign rb        = bus.IR[22:19];
    assign rc        = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    always_comb begin
        alu_sel  = '0;
        op_legal = 1'b1;
        case (opcode)
            5'b00011: alu_sel[0]  = 1'b1;   // ADD
            5'b00100: alu_sel[1]  = 1'b1;   // SUB
            5'b01111: alu_sel[2]  = 1'b1;   // MUL
            5'b10000: alu_sel[3]  = 1'b1;   // DIV
            5'b01010: alu_sel[4]  = 1'b1;   // AND
            5'b01011: alu_sel[5]  = 1'b1;   // OR
            5'b00101: alu_sel[6]  = 1'b1;   // SHR
            5'b00110: alu_sel[7]  = 1'b1;   // SHRA
            5'b00111: alu_sel[8]  = 1'b1;   // SHL
            5'b01000: alu_sel[9]  = 1'b1;   // ROR
            5'b01001: alu_sel[10] = 1'b1;   // ROL
            5'b10001: alu_sel[11] = 1'b1;   // NEG
            5'b10010: alu_sel[12] = 1'b1;   // NOT
            default:  op_legal    = 1'b0;
        endcase
    end

    assign is_muldiv = alu_sel[2] | alu_sel[3];
    assign is_unary  = alu_sel[11] | alu_sel[12];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_T0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // wait_q counts down the remaining T1 stall budget, armed in T0
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_T0: begin
                state_d = S_T1;
                wait_d  = WAIT_LOAD;
            end
            S_T1: begin
                if (bus.mem_ready) begin
                    state_d = S_T2;
                end else if (wait_q == '0) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_T2: state_d = is_unary ? S_T4 : S_T3;
            S_T3: begin
                if (op_legal) begin
                    state_d = S_T4;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = is_muldiv ? S_T6 : S_DONE;
            S_T6: state_d = S_DONE;
            S_HALT: state_d = S_HALT;
`ifdef CONTROL_STEP_EN
            S_WAIT: if (step) state_d = S_T0;
`endif
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        bus.Rin       = '0;
        bus.Rout      = '0;
        bus.PCout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.MDMuxread = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.alu_ctl   = '0;
        bus.run       = 1'b1;
        case (state_q)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.MDMuxread = 1'b1;
                // PC and MDR load only on the accepting cycle so PC moves once
                if (bus.mem_ready) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.MDRin   = 1'b1;
                end
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (op_legal) begin
                    bus.Rout = onehot16(rb);
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.alu_ctl = alu_sel;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = is_muldiv;
                bus.Rout    = onehot16(is_unary ? rb : rc);
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv) bus.LOin = 1'b1;
                else           bus.Rin  = onehot16(ra);
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            default: bus.run = 1'b0;
        endcase
    end

    assign bus.illegal     = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state_q;

endmodule
